// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider/multiplier family.
package fp_div_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    typedef struct packed {
        logic nan;
        logic neg_inf;
        logic pos_inf;
        logic pos_zero;
        logic neg_zero;
    } flags_t;

    function automatic flags_t inf_flags(input logic sign);
        flags_t f;
        f         = '0;
        f.neg_inf = sign;
        f.pos_inf = !sign;
        return f;
    endfunction

    function automatic flags_t zero_flags(input logic sign);
        flags_t f;
        f          = '0;
        f.neg_zero = sign;
        f.pos_zero = !sign;
        return f;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier; denormals report as zero.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] word,
    output op_class_t   op_class_c,
    output logic        sign_c
);

    always_comb begin
        op_class_c = CLS_NORMAL;
        sign_c     = word[31];
        if (word[30:23] == 8'(EXP_MAX)) begin
            op_class_c = (word[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (word[30:23] == 8'd0) begin
            op_class_c = CLS_ZERO;
        end
    end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 single multiplier, MUL_STEP multiplier bits per cycle.
// Rounding: truncation by default, round-to-nearest-even when FP_MUL_RNE_EN is defined.
module fp_mult_seq
    import fp_div_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        NaN,
    output logic        neg_infinite,
    output logic        pos_infinite,
    output logic        pos_zero,
    output logic        neg_zero
);

    localparam int unsigned NUM_STEPS = 24 / MUL_STEP;
    localparam int unsigned SUM_W     = 48 + MUL_STEP;
    localparam int unsigned CNT_W     = 5;
    localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

    state_t            state;
    flags_t            flags_q;
    logic              sign_q;
    logic [23:0]       mcand;
    logic [23:0]       mplier;
    logic [47:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic signed [9:0] exp_sum;

    op_class_t class_a, class_b;
    logic      sign_a, sign_b;

    fp_classify u_class_a (.word(a), .op_class_c(class_a), .sign_c(sign_a));
    fp_classify u_class_b (.word(b), .op_class_c(class_b), .sign_c(sign_b));

    // Special-operand decode on the raw inputs, used only at acceptance.
    logic any_nan, any_inf, any_zero, res_nan, special, sign_ab;
    always_comb begin
        any_nan  = (class_a == CLS_NAN)  || (class_b == CLS_NAN);
        any_inf  = (class_a == CLS_INF)  || (class_b == CLS_INF);
        any_zero = (class_a == CLS_ZERO) || (class_b == CLS_ZERO);
        res_nan  = any_nan || (any_inf && any_zero);
        special  = any_nan || any_inf || any_zero;
        sign_ab  = sign_a ^ sign_b;
    end

    // One radix-2^MUL_STEP shift-add step; the accumulator shifts right as digits retire.
    logic [SUM_W-1:0] partial, step_sum;
    logic [47:0]      acc_next;
    always_comb begin
        partial  = SUM_W'(mcand) * SUM_W'(mplier[MUL_STEP-1:0]);
        step_sum = SUM_W'(acc) + (partial << 24);
        acc_next = 48'(step_sum >> MUL_STEP);
    end

    // Normalise, round and form the final exponent.
    logic [22:0]       norm_frac;
    logic signed [9:0] norm_exp;
    logic [23:0]       rnd_sum;
    logic signed [9:0] fin_exp;
`ifdef FP_MUL_RNE_EN
    logic round_up;
`endif
    always_comb begin
        if (acc[47]) begin
            norm_frac = acc[46:24];
            norm_exp  = exp_sum + 10'sd1;
        end else begin
            norm_frac = acc[45:23];
            norm_exp  = exp_sum;
        end
        rnd_sum = {1'b0, norm_frac};
`ifdef FP_MUL_RNE_EN
        if (acc[47]) begin
            round_up = acc[23] & ((|acc[22:0]) | norm_frac[0]);
        end else begin
            round_up = acc[22] & ((|acc[21:0]) | norm_frac[0]);
        end
        rnd_sum = {1'b0, norm_frac} + 24'(round_up);
`endif
        fin_exp = norm_exp + $signed({9'd0, rnd_sum[23]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_product <= '0;
            flags_q     <= '0;
            sign_q      <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            exp_sum     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_q   <= sign_ab;
                        if (special) begin
                            state <= ST_DONE;
                            if (res_nan) begin
                                out_product <= QNAN;
                                flags_q     <= '{nan: 1'b1, default: 1'b0};
                            end else if (any_inf) begin
                                out_product <= {sign_ab, 8'hFF, 23'd0};
                                flags_q     <= inf_flags(sign_ab);
                            end else begin
                                out_product <= {sign_ab, 31'd0};
                                flags_q     <= zero_flags(sign_ab);
                            end
                        end else begin
                            state   <= ST_MUL;
                            mcand   <= {1'b1, a[22:0]};
                            mplier  <= {1'b1, b[22:0]};
                            acc     <= '0;
                            cnt     <= '0;
                            exp_sum <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
                                       - $signed(10'(EXP_BIAS));
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_STEPS - 1)) begin
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    state <= ST_DONE;
                    if (fin_exp >= EXP_MAX_S) begin
                        out_product <= {sign_q, 8'hFF, 23'd0};
                        flags_q     <= inf_flags(sign_q);
                    end else if (fin_exp <= 10'sd0) begin
                        out_product <= {sign_q, 31'd0};
                        flags_q     <= zero_flags(sign_q);
                    end else begin
                        out_product <= {sign_q, fin_exp[7:0], rnd_sum[22:0]};
                        flags_q     <= '0;
                    end
                end
                ST_DONE: begin
                    // Result registers settle on entry; out_valid follows one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign NaN          = flags_q.nan;
    assign neg_infinite = flags_q.neg_inf;
    assign pos_infinite = flags_q.pos_inf;
    assign pos_zero     = flags_q.pos_zero;
    assign neg_zero     = flags_q.neg_zero;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq: directed vectors, latency, hold and reset behaviour.
module tb_fp_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        NaN, neg_infinite, pos_infinite, pos_zero, neg_zero;

    always #5 clk = ~clk;

    fp_mult_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .NaN(NaN), .neg_infinite(neg_infinite), .pos_infinite(pos_infinite),
        .pos_zero(pos_zero), .neg_zero(neg_zero)
    );

    // Flag vector order: {NaN, neg_inf, pos_inf, pos_zero, neg_zero}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NAN  = 5'b10000;
    localparam logic [4:0] F_NINF = 5'b01000;
    localparam logic [4:0] F_PINF = 5'b00100;
    localparam logic [4:0] F_PZ   = 5'b00010;
    localparam logic [4:0] F_NZ   = 5'b00001;

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

    typedef struct packed {
        logic [31:0] prod;
        logic [4:0]  flags;
        logic [7:0]  id;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   next_id = 0;

    logic [4:0] flags_w;
    assign flags_w = {NaN, neg_infinite, pos_infinite, pos_zero, neg_zero};

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, req);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected output", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("product #%0d", e.id), out_product, e.prod);
                check($sformatf("flags #%0d", e.id), 32'(flags_w), 32'(e.flags));
            end
        end
    end

    task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] prod, input logic [4:0] flg,
                          input int lat, input int hold);
        int          cyc;
        logic [31:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready before accept", 32'(in_ready), 32'd1);
        a        = a_v;
        b        = b_v;
        in_valid = 1'b1;
        sb.push_back('{prod: prod, flags: flg, id: 8'(next_id)});
        next_id++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        check("in_ready after accept", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        held = out_product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold product", out_product, held);
            check("hold valid/ready", {31'd0, out_valid} | {30'd0, in_ready, 1'b0}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid release", 32'(out_valid), 32'd0);
        check("in_ready release", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset product", out_product, 32'd0);
        check("reset flags", 32'(flags_w), 32'd0);

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, F_NONE, 26, 0);
        run_op(32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, F_NONE, 26, 10);
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, F_NAN,  1,  0);
        run_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, F_NINF, 1,  0);
        run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, F_PINF, 26, 0);
        run_op(32'h8080_0000, 32'h0080_0000, 32'h8000_0000, F_NZ,   26, 0);
        run_op(32'h3FC0_0001, 32'h3FC0_0001, RND_EXP,       F_NONE, 26, 0);
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, F_NAN,  1,  0);
        run_op(32'hFFC0_0000, 32'hFF80_0000, 32'h7FC0_0000, F_NAN,  1,  0);
        run_op(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, F_PZ,   1,  0);
        run_op(32'hFF80_0000, 32'hC000_0000, 32'h7F80_0000, F_PINF, 1,  0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, F_NONE, 26, 0);
        run_op(32'h3F80_0000, 32'h8000_0000, 32'h8000_0000, F_NZ,   1,  3);

        // Abort a multiply mid-flight with reset; nothing should be produced.
        a        = 32'h4000_0000;
        b        = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        check("post-reset out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("aborted result suppressed", 32'(seen), 32'd0);

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, F_NONE, 26, 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_mult_seq.md
# fp_mult_seq

Sequential IEEE-754 single-precision multiplier with valid/ready handshakes on both sides. It is the inverse-direction companion to the Goldschmidt divider. It recomputes quotient×denominator for divider self-check and serves as the shared multiplier for future iterative datapaths. It reports the same five result flags as the divider: NaN, ±infinity and ±zero.

## Interface
- MUL_STEP, 1: multiplier bits retired per cycle. Legal values are 1, 2, 4, 8 (must divide 24).
- clk  input  1  clock. All logic samples on the rising edge.
- rst  input  1  reset. Synchronous, active-high.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  32  multiplicand, IEEE-754 single.
- b  input  32  multiplier, IEEE-754 single.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- out_product  output  32  product, IEEE-754 single.
- NaN, neg_infinite, pos_infinite, pos_zero, neg_zero  output  1 each  result-class flags, valid with out_valid.

## Operation
- **FSM states:** IDLE, MUL, NORM, DONE.
  - IDLE → MUL on in_valid&&in_ready when both operands are normal.
  - IDLE → DONE on acceptance when either operand is special.
  - MUL → NORM after 24/MUL_STEP cycles.
  - NORM → DONE.
  - DONE → IDLE on out_ready.
- **Operand latch:** operands are captured on acceptance; a/b are don't-care afterwards.
- **Classification:**
  - exp=255 and mant≠0: NaN.
  - exp=255 and mant=0: inf.
  - exp=0: zero. Denormals are flushed to zero, sign preserved.
- **Special results (priority order):**
  - Either operand NaN, or inf×zero: out_product=32'h7FC0_0000, NaN=1.
  - Else either operand inf: {sign,8'hFF,23'h0}.
  - Else either operand zero: {sign,31'h0}.
- **Sign:** a[31]^b[31] in all cases except NaN, which has sign 0.
- **Normal path:**
  - 24×24 unsigned shift-add product over 1.M significands into a 48-bit accumulator, MUL_STEP bits per cycle, LSB first.
  - Exponent: 10-bit signed sum ea+eb−127.
- **NORM:**
  - If product[47]=1: shift right 1, exponent+1.
  - Fraction = next 23 bits.
- **Rounding:** see Configuration.
- **Exponent limits:**
  - Final exponent ≥255: ±inf with the matching inf flag.
  - Final exponent ≤0: signed zero with the matching zero flag.
- **Flags:** exactly one flag or none is high while out_valid=1. Normal finite results raise no flag.
- **Reset values:** all outputs 0 except in_ready=1; state IDLE.

## Timing
- Acceptance edge = cycle 0.
- Normal operands: out_valid rises after edge 24/MUL_STEP+2 (26 at default).
- Special operands: out_valid rises after edge 1.
- Output hold: out_product and flags stay stable while out_valid && !out_ready.
- Output release: out_valid drops the cycle after the out_ready handshake, and in_ready rises in that same cycle. No back-to-back accept in the handshake cycle.
- in_ready is 0 from acceptance until return to IDLE; in_valid is ignored meanwhile.
- rst has priority over everything. rst in any state returns to IDLE next edge with out_valid=0 and in_ready=1. A partial result is discarded.

## Configuration
- FP_MUL_RNE_EN defined:
  - Round-to-nearest-even using guard bit and sticky OR of the remaining discarded bits.
  - Round-up carry out of the fraction increments the exponent, then the overflow check is applied.
  - Latency is unchanged; rounding happens in NORM.
- FP_MUL_RNE_EN undefined: truncation, matching the divider's float_mult behaviour.

## Structure
- Shared package fp_div_pkg holds:
  - EXP_BIAS=127, QNAN=32'h7FC0_0000, EXP_MAX=255.
  - FSM state enum.
  - Operand-class enum (NORMAL, ZERO, INF, NAN).
- One sub-module, fp_classify: combinational 32-bit word → class and sign. Two instances, one per operand. Reusable by the divider.

## Test plan
- 0x40000000×0x40400000 (2×3) → 0x40C00000, no flags, out_valid 26 cycles after accept (MUL_STEP=1).
- 0x3FC00000×0xBFC00000 → 0xC0100000. Hold out_ready=0 for 10 cycles: output stable, in_ready=0.
- 0x7F800000×0x00000000 → 0x7FC00000, NaN=1, out_valid 1 cycle after accept. 0xFF800000×0x3F800000 → 0xFF800000, neg_infinite=1.
- 0x7F000000×0x7F000000 → 0x7F800000, pos_infinite=1. 0x80800000×0x00800000 → 0x80000000, neg_zero=1.
- 0x3FC00001×0x3FC00001 → 0x40100001 without FP_MUL_RNE_EN, 0x40100002 with it.
- rst pulsed at cycle 10 of a MUL → next cycle in_ready=1, out_valid=0. A fresh 2×3 then yields 0x40C00000.
